// File: rtl/playback_sequencer_pkg.sv
// Shared types for the frame-animation playback path.
package playback_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_DONE    = 2'd3
  } pb_state_t;

endpackage

// File: rtl/playback_sequencer_edge_sync.sv
// Two-flop synchronizer followed by a single-cycle rising-edge detector.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;

endmodule

// File: rtl/playback_sequencer.sv
// Frame-advance sequencer: vsync-derived tick, frame counter, and MIDI player gating.
module playback_sequencer
  import playback_pkg::*;
#(
  parameter int NUM_FRAMES  = 2608,
  parameter int FRAME_DIV   = 5,
  parameter int AUDIO_START = 184,
  parameter int LOOP        = 0,
  localparam int FW         = $clog2(NUM_FRAMES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vsync_in,
  input  logic          cmd_play,
  input  logic          cmd_pause,
  input  logic          cmd_restart,
  output logic [FW-1:0] frame_num,
  output logic          frame_advance,
  output logic          audio_play,
  output logic          audio_rst,
  output logic [1:0]    state,
  output logic          done
);

  localparam int            DW       = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [FW-1:0] LAST     = FW'(NUM_FRAMES - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(FRAME_DIV - 1);

  pb_state_t     st;
  logic [DW-1:0] divider;
  logic          vs_rise;

  function automatic logic audible(input logic [FW-1:0] f);
    return 32'(f) >= AUDIO_START;
  endfunction

  edge_sync u_vsync (
    .clk  (clk),
    .rst  (rst),
    .din  (vsync_in),
    .rise (vs_rise)
  );

  // audio_play is computed from the values being loaded this cycle so it
  // tracks frame_num/state without an extra cycle of lag.
  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= ST_IDLE;
      frame_num     <= '0;
      divider       <= '0;
      frame_advance <= 1'b0;
      audio_play    <= 1'b0;
      audio_rst     <= 1'b1;
      done          <= 1'b0;
    end else begin
      frame_advance <= 1'b0;
      audio_rst     <= 1'b0;
      if (cmd_restart) begin
        st         <= ST_PLAYING;
        frame_num  <= '0;
        divider    <= '0;
        audio_rst  <= 1'b1;
        audio_play <= audible('0);
        done       <= 1'b0;
      end else if (cmd_pause && st == ST_PLAYING) begin
        st         <= ST_PAUSED;
        audio_play <= 1'b0;
      end else if (cmd_play && !cmd_pause && (st == ST_IDLE || st == ST_PAUSED)) begin
        st         <= ST_PLAYING;
        audio_play <= audible(frame_num);
      end else if (st == ST_PLAYING && vs_rise) begin
        if (divider != DIV_LAST) begin
          divider <= divider + 1'b1;
        end else begin
          divider <= '0;
          if (frame_num != LAST) begin
            frame_num     <= frame_num + 1'b1;
            frame_advance <= 1'b1;
            audio_play    <= audible(frame_num + 1'b1);
          end else if (LOOP != 0) begin
            frame_num     <= '0;
            frame_advance <= 1'b1;
            audio_rst     <= 1'b1;
            audio_play    <= audible('0);
          end else begin
            st         <= ST_DONE;
            done       <= 1'b1;
            audio_play <= 1'b0;
          end
        end
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_playback_sequencer.sv
// Directed bench with an advance scoreboard; a second instance covers the wrap-around build.
module tb_playback_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vsync_in = 1'b0;
  logic cmd_play = 1'b0;
  logic cmd_pause = 1'b0;
  logic cmd_restart = 1'b0;

  logic [2:0] frame_num, l_frame_num;
  logic       frame_advance, l_frame_advance;
  logic       audio_play, l_audio_play;
  logic       audio_rst, l_audio_rst;
  logic [1:0] state, l_state;
  logic       done, l_done;

  int  n_checks = 0;
  int  n_fail = 0;
  int  loop_wraps = 0;
  bit  mon_en = 1'b0;

  typedef struct {
    int frame;
    int audio;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  playback_sequencer #(
    .NUM_FRAMES (8),
    .FRAME_DIV  (3),
    .AUDIO_START(2),
    .LOOP       (0)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .vsync_in     (vsync_in),
    .cmd_play     (cmd_play),
    .cmd_pause    (cmd_pause),
    .cmd_restart  (cmd_restart),
    .frame_num    (frame_num),
    .frame_advance(frame_advance),
    .audio_play   (audio_play),
    .audio_rst    (audio_rst),
    .state        (state),
    .done         (done)
  );

  playback_sequencer #(
    .NUM_FRAMES (8),
    .FRAME_DIV  (3),
    .AUDIO_START(2),
    .LOOP       (1)
  ) u_loop (
    .clk          (clk),
    .rst          (rst),
    .vsync_in     (vsync_in),
    .cmd_play     (cmd_play),
    .cmd_pause    (cmd_pause),
    .cmd_restart  (cmd_restart),
    .frame_num    (l_frame_num),
    .frame_advance(l_frame_advance),
    .audio_play   (l_audio_play),
    .audio_rst    (l_audio_rst),
    .state        (l_state),
    .done         (l_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_adv(input int f);
    exp_t e;
    e.frame = f;
    e.audio = (f >= 2) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  task automatic vsync_pulse();
    @(negedge clk) vsync_in = 1'b1;
    repeat (6) @(negedge clk);
    vsync_in = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_cmd(input bit r, input bit p, input bit pl);
    @(negedge clk);
    cmd_restart = r;
    cmd_pause   = p;
    cmd_play    = pl;
    @(negedge clk);
    cmd_restart = 1'b0;
    cmd_pause   = 1'b0;
    cmd_play    = 1'b0;
  endtask

  // Every frame_advance strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (frame_advance === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_advance", {29'd0, frame_num}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("adv_frame", {29'd0, frame_num}, e.frame);
          check("adv_audio", {31'd0, audio_play}, e.audio);
        end
      end
      if (l_frame_advance === 1'b1 && l_frame_num === 3'd0) begin
        loop_wraps++;
        check("wrap_audio_rst", {31'd0, l_audio_rst}, 1);
        check("wrap_audio_play", {31'd0, l_audio_play}, 0);
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_state", {30'd0, state}, 0);
    check("rst_frame", {29'd0, frame_num}, 0);
    check("rst_audio_rst", {31'd0, audio_rst}, 1);
    check("rst_audio_play", {31'd0, audio_play}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_advance", {31'd0, frame_advance}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_audio_rst_pulse", {31'd0, audio_rst}, 0);
    mon_en = 1'b1;

    // Basic playback
    pulse_cmd(0, 0, 1);
    check("play_state", {30'd0, state}, 1);
    check("play_audio", {31'd0, audio_play}, 0);
    for (int i = 1; i <= 6; i++) begin
      if (i == 3) push_adv(1);
      if (i == 6) push_adv(2);
      vsync_pulse();
      if (i == 3) check("basic_frame1", {29'd0, frame_num}, 1);
    end
    check("basic_frame2", {29'd0, frame_num}, 2);
    check("basic_audio", {31'd0, audio_play}, 1);

    // Pause two vsyncs into a period, then resume
    repeat (2) vsync_pulse();
    pulse_cmd(0, 1, 0);
    check("pause_state", {30'd0, state}, 2);
    check("pause_audio", {31'd0, audio_play}, 0);
    repeat (5) vsync_pulse();
    check("paused_frame", {29'd0, frame_num}, 2);
    pulse_cmd(0, 0, 1);
    check("resume_state", {30'd0, state}, 1);
    check("resume_audio", {31'd0, audio_play}, 1);
    push_adv(3);
    vsync_pulse();
    check("resume_frame", {29'd0, frame_num}, 3);

    // Restart+pause coinciding with a vs_rise that would advance frame 5
    push_adv(4);
    for (int i = 1; i <= 6; i++) begin
      if (i == 6) push_adv(5);
      vsync_pulse();
    end
    check("pre_sim_frame", {29'd0, frame_num}, 5);
    repeat (2) vsync_pulse();
    @(negedge clk) vsync_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cmd_restart = 1'b1;
    cmd_pause   = 1'b1;
    @(negedge clk);
    cmd_restart = 1'b0;
    cmd_pause   = 1'b0;
    check("sim_frame", {29'd0, frame_num}, 0);
    check("sim_state", {30'd0, state}, 1);
    check("sim_audio_rst", {31'd0, audio_rst}, 1);
    check("sim_advance", {31'd0, frame_advance}, 0);
    check("sim_audio", {31'd0, audio_play}, 0);
    @(negedge clk);
    check("sim_audio_rst_pulse", {31'd0, audio_rst}, 0);
    vsync_in = 1'b0;
    repeat (8) @(negedge clk);
    repeat (2) vsync_pulse();
    check("sim_div_cleared", {29'd0, frame_num}, 0);
    push_adv(1);
    vsync_pulse();

    // Mid-run reset at frame 4
    for (int i = 1; i <= 9; i++) begin
      if (i % 3 == 0) push_adv(1 + i / 3);
      vsync_pulse();
    end
    check("pre_rst_frame", {29'd0, frame_num}, 4);
    check("pre_rst_audio", {31'd0, audio_play}, 1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("midrst_state", {30'd0, state}, 0);
    check("midrst_frame", {29'd0, frame_num}, 0);
    check("midrst_audio", {31'd0, audio_play}, 0);
    check("midrst_audio_rst", {31'd0, audio_rst}, 1);
    @(negedge clk);
    check("midrst_audio_rst_pulse", {31'd0, audio_rst}, 0);

    // Run to the end: stop build halts at 7, wrap build returns to 0
    pulse_cmd(0, 0, 1);
    for (int i = 1; i <= 24; i++) begin
      if (i % 3 == 0 && i <= 21) push_adv(i / 3);
      vsync_pulse();
    end
    check("end_frame", {29'd0, frame_num}, 7);
    check("end_state", {30'd0, state}, 3);
    check("end_done", {31'd0, done}, 1);
    check("end_audio", {31'd0, audio_play}, 0);
    check("loop_wraps", loop_wraps, 1);
    check("loop_frame0", {29'd0, l_frame_num}, 0);
    check("loop_state", {30'd0, l_state}, 1);
    check("loop_done", {31'd0, l_done}, 0);
    repeat (3) vsync_pulse();
    check("end_hold_frame", {29'd0, frame_num}, 7);
    check("loop_frame1", {29'd0, l_frame_num}, 1);
    check("loop_audio_low", {31'd0, l_audio_play}, 0);
    pulse_cmd(0, 0, 1);
    check("end_play_ignored", {30'd0, state}, 3);
    check("loop_play_ignored", {30'd0, l_state}, 1);
    repeat (3) vsync_pulse();
    check("end_hold_frame2", {29'd0, frame_num}, 7);
    check("loop_frame2", {29'd0, l_frame_num}, 2);
    check("loop_audio_back", {31'd0, l_audio_play}, 1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/playback_sequencer.md
Name: playback_sequencer

Overview:
Central sequencer for the frame-animation playback path. Derives the frame-advance tick from VGA vsync, owns the frame counter that indexes the frame ROM, and gates/re-arms the MIDI song player so audio stays locked to video. Sits between the pixel-clock VGA driver, the frame ROM, the MIDI player and the board button/switch inputs. Runs entirely in the 50 MHz `clk` domain.

Parameters:
- NUM_FRAMES, 2608, total frames in the ROM; valid frame_num range is 0..NUM_FRAMES-1.
- FRAME_DIV, 5, number of vsync rising edges per frame advance (60 Hz / 5 = 12 fps).
- AUDIO_START, 184, first frame_num at which audio_play may assert.
- LOOP, 0, 1 = wrap to frame 0 after the last frame; 0 = stop in DONE.
- FW, $clog2(NUM_FRAMES), width of frame_num (derived; not overridden).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- vsync_in  in  1  raw VGA vsync from the pixel-clock domain; asynchronous to clk.
- cmd_play  in  1  one-cycle pulse.
- cmd_pause  in  1  one-cycle pulse.
- cmd_restart  in  1  one-cycle pulse.
- frame_num  out  FW  current frame index to the frame ROM.
- frame_advance  out  1  one-cycle strobe; asserted in the same cycle frame_num takes its new value.
- audio_play  out  1  enable to the MIDI player.
- audio_rst  out  1  one-cycle pulse that rewinds the MIDI player.
- state  out  2  encoded FSM state, for the LEDs and 7-segment display.
- done  out  1  high while in DONE.

Behaviour:
- Reset (rst=1 at a clk edge) forces the following on the next cycle:
  - state=IDLE, frame_num=0, divider=0;
  - frame_advance=0, audio_play=0, done=0;
  - audio_rst=1 for exactly one cycle;
  - synchronizer flops cleared.
- Vsync input path:
  - 2-flop synchronizer, then a registered previous value.
  - vs_rise = sync & ~prev.
  - A vsync_in rising edge raises vs_rise internally 2-3 clk later.
  - Exactly one vs_rise per vsync edge.
- FSM states, encoded: IDLE=0, PLAYING=1, PAUSED=2, DONE=3.
- Command priority, evaluated per cycle: restart > pause > play. Only the highest-priority pulse present acts.
  - cmd_restart, any state: frame_num<=0, divider<=0, audio_rst pulse, state<=PLAYING.
  - cmd_pause: PLAYING->PAUSED only; ignored in all other states.
  - cmd_play: IDLE->PLAYING and PAUSED->PLAYING; ignored in PLAYING and DONE.
- Divider:
  - Counts vs_rise only while state==PLAYING and no command acts that cycle.
  - On vs_rise with divider==FRAME_DIV-1: divider<=0, and frame advance occurs.
  - Otherwise on vs_rise: divider increments.
  - PAUSED holds the divider value, so resume continues mid-period.
- Frame advance when frame_num < NUM_FRAMES-1: frame_num+1, frame_advance=1.
- Frame advance at frame_num == NUM_FRAMES-1:
  - LOOP=1: frame_num<=0, frame_advance=1, audio_rst pulse, stay PLAYING.
  - LOOP=0: state<=DONE, frame_num holds at NUM_FRAMES-1, frame_advance=0.
- audio_play is registered: audio_play <= (next state==PLAYING) && (next frame_num >= AUDIO_START). It deasserts in the same cycle as PAUSED/DONE entry and on restart.
- done is registered and equals (state==DONE).
- vs_rise arriving in the same cycle as a command: the command wins and that vs_rise is discarded.
- frame_num arithmetic is unsigned FW-bit and never exceeds NUM_FRAMES-1.

Decomposition:
- Package playback_pkg: state enum typedef (pb_state_t, 2-bit) and the state encodings.
- Sub-module edge_sync: 2-flop synchronizer plus rising-edge detector, reused for button inputs elsewhere.
- The FSM, divider and frame counter stay in playback_sequencer.

Test Plan:
- Test-plan parameters: NUM_FRAMES=8, FRAME_DIV=3, AUDIO_START=2, LOOP=0.
- Basic playback: reset, cmd_play, then 6 vsync pulses -> frame_advance strobes on the 3rd and 6th vs_rise; frame_num=2 after them; audio_play rises in the cycle frame_num becomes 2.
- Pause/resume: pause after 2 vsyncs into a period, then 5 vsyncs, then cmd_play and 1 vsync -> no advance while paused; the advance occurs on the first vsync after resume (divider held at 2).
- End, LOOP=0: run 24 vsyncs -> frame_num stops at 7; state=3; done=1; audio_play=0; further vsyncs leave frame_num at 7; cmd_play is ignored.
- End, LOOP=1: same run -> after frame 7 the next advance gives frame_num=0 with frame_advance=1 and audio_rst=1 in the same cycle; audio_play drops until frame 2.
- Simultaneous events: cmd_restart and cmd_pause in the same cycle as a vs_rise at frame 5 -> frame_num=0, divider=0, state=PLAYING, audio_rst pulse, no frame_advance.
- Mid-run reset: assert rst at frame 4 -> next cycle state=0, frame_num=0, audio_play=0, audio_rst=1 for one cycle.
